// File: rtl/pad_rx_pkg.sv
// Shared types and limits for the pad receive filter family.
`timescale 1ns/1ps
package pad_rx_pkg;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_QUAL_HI,
        ST_HIGH,
        ST_QUAL_LO
    } pad_rx_state_t;

    localparam int PAD_RX_SYNC_MIN = 2;
    localparam int PAD_RX_SYNC_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// N-flop level synchronizer with async active-low reset to 0; reusable by any pad block.
`timescale 1ns/1ps
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    if (N < 2) begin : g_bad_n
        $error("sync_chain: N must be at least 2");
    end

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/pad_rx_filter.sv
// Pad receive conditioning: synchronize, debounce over FILT_CYCLES samples, emit level and edge/glitch pulses.
// Optional build macro PAD_RX_INVERT_EN complements level_o and swaps rise_o/fall_o to match.
`timescale 1ns/1ps
module pad_rx_filter
    import pad_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic glitch_o
);

    if (SYNC_STAGES < PAD_RX_SYNC_MIN || SYNC_STAGES > PAD_RX_SYNC_MAX) begin : g_bad_sync
        $error("pad_rx_filter: SYNC_STAGES out of range 2..4");
    end
    if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
        $error("pad_rx_filter: FILT_CYCLES out of range 1..255");
    end

    localparam int                CNT_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

`ifdef PAD_RX_INVERT_EN
    localparam logic LEVEL_RST = 1'b1;
`else
    localparam logic LEVEL_RST = 1'b0;
`endif

    logic s;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pad_i),
        .q_o   (s)
    );

    pad_rx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic             filt_rise, filt_fall, filt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            level_q  <= LEVEL_RST;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        filt_rise = 1'b0;
        filt_fall = 1'b0;
        glitch_d  = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (s) begin
                    if (FILT_CYCLES == 1) begin
                        state_d   = ST_HIGH;
                        cnt_d     = '0;
                        filt_rise = 1'b1;
                    end else begin
                        state_d = ST_QUAL_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_QUAL_HI: begin
                if (!s) begin
                    state_d  = ST_LOW;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_HIGH;
                    cnt_d     = '0;
                    filt_rise = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (FILT_CYCLES == 1) begin
                        state_d   = ST_LOW;
                        cnt_d     = '0;
                        filt_fall = 1'b1;
                    end else begin
                        state_d = ST_QUAL_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_QUAL_LO: begin
                if (s) begin
                    state_d  = ST_HIGH;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_LOW;
                    cnt_d     = '0;
                    filt_fall = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        // Filtered level stays at its old value while a change is still qualifying.
        filt_d = (state_d == ST_HIGH) || (state_d == ST_QUAL_LO);
`ifdef PAD_RX_INVERT_EN
        level_d = ~filt_d;
        rise_d  = filt_fall;
        fall_d  = filt_rise;
`else
        level_d = filt_d;
        rise_d  = filt_rise;
        fall_d  = filt_fall;
`endif
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign glitch_o = glitch_q;

endmodule

// File: doc/pad_rx_filter.md
# pad_rx_filter

Receive-side conditioning block for a single asynchronous pad input driven by the team's switch-level inverter/output stage. It synchronizes the pad into the `clk` domain, accepts a new level only after it has been stable for a programmable number of cycles, and emits a clean level with single-cycle rise, fall and glitch pulses. It sits directly behind the input buffer (IB) of any pad whose far end is a CMOS inverter driver.

## Interface

- `SYNC_STAGES`, default 2: synchronizer flops; legal range 2..4.
- `FILT_CYCLES`, default 4: number of consecutive equal synchronized samples required to accept a level; legal range 1..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to `clk` externally.
- `pad_i`  in  1  raw pad level, asynchronous to `clk`.
- `level_o`  out  1  filtered, registered level.
- `rise_o`  out  1  one-cycle pulse on the cycle `level_o` goes 0->1.
- `fall_o`  out  1  one-cycle pulse on the cycle `level_o` goes 1->0.
- `glitch_o`  out  1  one-cycle pulse when a qualifying change is aborted.

## Operation

- Synchronizer: `SYNC_STAGES` flops, reset to 0; its last stage is `s`.
- FSM states: `ST_LOW`, `ST_QUAL_HI`, `ST_HIGH`, `ST_QUAL_LO`; reset state `ST_LOW`.
- Counter `cnt`, width `$clog2(FILT_CYCLES+1)`, reset 0, cleared on every transition into a stable state.
- `ST_LOW`: s=0 -> stay. s=1 -> if FILT_CYCLES=1, go to `ST_HIGH` directly; else go to `ST_QUAL_HI` with cnt=1.
- `ST_QUAL_HI`: s=1 and cnt=FILT_CYCLES-1 -> `ST_HIGH`, set level, pulse rise. s=1 otherwise -> cnt+1. s=0 -> `ST_LOW`, pulse glitch, cnt=0.
- `ST_HIGH` and `ST_QUAL_LO` mirror the above with 0/1 swapped and `fall_o` instead of `rise_o`.
- The filtered level is 1 exactly in `ST_HIGH` and `ST_QUAL_LO`. The counter never exceeds FILT_CYCLES-1, so no wrap is possible.
- Reset values: `level_o`=0, `rise_o`=`fall_o`=`glitch_o`=0. With the invert feature enabled, `level_o`=1 (see Configuration).
- Reset mid-qualification aborts it silently, with no glitch pulse.
- Pad high at reset release: treated as a normal 0->1 change, so `rise_o` pulses once.
- At most one of `rise_o`, `fall_o`, `glitch_o` is high in any cycle.

## Timing

- All outputs are registered; no combinational path from `pad_i`.
- Latency: pad stable from before rising edge 1 -> `level_o` and its edge pulse update on edge SYNC_STAGES+FILT_CYCLES. Defaults give edge 6.
- Pulses last exactly one cycle.
- A pad pulse seen as fewer than FILT_CYCLES synchronized samples never changes `level_o`. It produces one `glitch_o` pulse on the edge that samples the reverted `s`.
- Minimum spacing between accepted edges is FILT_CYCLES cycles.

## Configuration

- `PAD_RX_INVERT_EN` defined:
  - `level_o` is the complement of the filtered level, restoring the signal before the far-end inverter.
  - `rise_o` and `fall_o` follow `level_o` polarity, so a pad 1->0 acceptance pulses `rise_o`.
  - Reset value of `level_o` is 1.
- `PAD_RX_INVERT_EN` undefined:
  - `level_o` equals the filtered pad level, with reset value 0.
- The FSM and `glitch_o` are identical in both builds.

## Structure

- Package `pad_rx_pkg` holds:
  - the state enum `pad_rx_state_t` with the four states above;
  - the constants `PAD_RX_SYNC_MIN`=2 and `PAD_RX_SYNC_MAX`=4.
- Sub-module `sync_chain`: parameterized N-flop synchronizer with async active-low reset to 0. It is instantiated once and is reusable by other pad blocks.
- Parameter legality is checked with elaboration-time assertions.

## Test plan

All scenarios use the defaults (SYNC_STAGES=2, FILT_CYCLES=4).

- Reset then pad=0 for 20 cycles -> `level_o`=0 (1 with invert) and no pulses throughout.
- Pad 0->1 held -> `level_o` rises with a single `rise_o` pulse on edge 6 after the change; no `glitch_o`.
- Pad high for 2 cycles, then low -> `level_o` unchanged; exactly one `glitch_o` pulse; no `rise_o`.
- Pad high for 3 synchronized samples, low for 1, high again held -> one `glitch_o` pulse, then a fresh 4-sample qualification; `rise_o` pulses 4 cycles after the re-rise reaches `s`.
- `rst_n` asserted while in `ST_QUAL_HI` at cnt=2 -> outputs return to reset values immediately with no pulse. After release with the pad held high, `rise_o` pulses on edge 6.
- `PAD_RX_INVERT_EN` build, pad 1->0 held -> `level_o` 0->1 with a `rise_o` pulse on edge 6; pad 0->1 -> `fall_o`.
